// File: rtl/fact_pkg.sv
// rtl/fact_pkg.sv - shared state codes and parameter defaults for the factorial controller
package fact_pkg;

  localparam int N_W_DEF      = 4;
  localparam int N_MAX_DEF    = 12;
  localparam int WDOG_MAX_DEF = 15;

  // Encodings double as the cs debug code driven to the LEDs.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CMP  = 3'd2,
    S_MUL  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

endpackage

// File: rtl/fact_ctrl_wdog.sv
// rtl/fact_ctrl_wdog.sv - MUL iteration counter with limit flag (used when FACT_CTRL_WDOG_EN is defined)
module fact_ctrl_wdog
  import fact_pkg::*;
#(
  parameter int WDOG_MAX = WDOG_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  localparam int CW = $clog2(WDOG_MAX + 1);
  localparam logic [CW-1:0] MAX_V = WDOG_MAX[CW-1:0];

  logic [CW-1:0] count;

  // Count MUL cycles since the last LOAD; the controller never lets it pass MAX_V.
  always_ff @(posedge clk) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count + CW'(1);
  end

  assign at_max = (count == MAX_V);

endmodule

// File: rtl/fact_ctrl.sv
// rtl/fact_ctrl.sv - Moore FSM sequencing the iterative factorial datapath; optional watchdog under FACT_CTRL_WDOG_EN
module fact_ctrl
  import fact_pkg::*;
#(
  parameter int N_W      = N_W_DEF,
  parameter int N_MAX    = N_MAX_DEF,
  parameter int WDOG_MAX = WDOG_MAX_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go,
  input  logic [N_W-1:0] n,
  input  logic           gt,
  output logic           cnt_ld,
  output logic           cnt_en,
  output logic           reg_ld,
  output logic           reg_sel,
  output logic           out_en,
  output logic           done,
  output logic           err,
  output logic [2:0]     cs
);

  localparam logic [N_W-1:0] N_MAX_V = N_MAX[N_W-1:0];

  state_t state, state_nxt;
  logic   wdog_trip;

`ifdef FACT_CTRL_WDOG_EN
  fact_ctrl_wdog #(
    .WDOG_MAX (WDOG_MAX)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == S_LOAD),
    .inc    (state == S_MUL),
    .at_max (wdog_trip)
  );
`else
  // No iteration limit: gt is trusted to fall eventually.
  logic wdog_unused;
  assign wdog_unused = (WDOG_MAX > 0);
  assign wdog_trip   = 1'b0;
`endif

  // State register; reset aborts any run at the next edge.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and Moore output decode; outputs depend on state only.
  always_comb begin
    state_nxt = state;
    cnt_ld    = 1'b0;
    cnt_en    = 1'b0;
    reg_ld    = 1'b0;
    reg_sel   = 1'b0;
    out_en    = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) state_nxt = (n > N_MAX_V) ? S_ERR : S_LOAD;
      end
      S_LOAD: begin
        cnt_ld    = 1'b1;
        reg_ld    = 1'b1;
        reg_sel   = 1'b0;
        state_nxt = S_CMP;
      end
      S_CMP: begin
        if (gt) state_nxt = wdog_trip ? S_ERR : S_MUL;
        else    state_nxt = S_DONE;
      end
      S_MUL: begin
        reg_ld    = 1'b1;
        reg_sel   = 1'b1;
        cnt_en    = 1'b1;
        state_nxt = S_CMP;
      end
      S_DONE: begin
        done   = 1'b1;
        out_en = 1'b1;
        if (!go) state_nxt = S_IDLE;
      end
      S_ERR: begin
        err = 1'b1;
        if (!go) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign cs = state;

endmodule
